// File: rtl/jtkunio_ba_arb.sv
// jtkunio_ba_arb
// Arbitrates four bank requesters onto a single SDRAM read port and inserts
// one refresh slot for each rising edge of the horizontal sync.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   hs                horizontal sync; a rising edge requests one refresh slot
//   ba0..3_addr       word address of each bank requester
//   ba_rd             per-bank read request (level, held until ba_ack)
//   ba_ack/dst/rdy    per-bank handshakes routed back from the SDRAM core
//   sdr_req           read request to the SDRAM core
//   sdr_addr, sdr_ba  granted address and bank number
//   sdr_rfsh          refresh command strobe (first refresh cycle only)
//   sdr_ack/dst/rdy   SDRAM core handshakes for the current request
//
// state | meaning
// IDLE  | arbitrate: refresh first, otherwise round-robin bank grant
// REQ   | sdr_req high, waiting for sdr_ack
// DATA  | burst in progress, waiting for sdr_rdy
// RFSH  | refresh slot, RFSH_CYC cycles long
module jtkunio_ba_arb #(
  parameter int RFSH_CYC = 8,
  parameter int RFSH_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic [3:0]  ba_rd,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_rdy,
  output logic        sdr_req,
  output logic [21:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_rfsh,
  input  logic        sdr_ack,
  input  logic        sdr_dst,
  input  logic        sdr_rdy
);

  localparam int CW = $clog2(RFSH_CYC) + 1;
  localparam logic [CW-1:0] RFSH_LOAD = CW'(RFSH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    RFSH = 2'd3
  } state_t;

  state_t        state;
  state_t        nx_state;
  logic          hs_l;
  logic          hs_rise;
  logic          rfsh_pend;
  logic          rfsh_due;
  logic          rfsh_first;
  logic [CW-1:0] rfsh_cnt;
  logic [1:0]    last_grant;
  logic [1:0]    rr_idx;
  logic [1:0]    rr_sel;
  logic          rr_hit;
  logic [3:0]    grant_oh;
  logic          go_req;
  logic          go_rfsh;

  function automatic logic [21:0] addr_of(input logic [1:0] sel,
                                          input logic [21:0] a0,
                                          input logic [21:0] a1,
                                          input logic [21:0] a2,
                                          input logic [21:0] a3);
    logic [21:0] a;
    case (sel)
      2'd0:    a = a0;
      2'd1:    a = a1;
      2'd2:    a = a2;
      default: a = a3;
    endcase
    return a;
  endfunction

  assign hs_rise = hs & ~hs_l;
  // The edge itself counts as due, so an hs edge coinciding with a request
  // in IDLE still wins over the request.
  assign rfsh_due = (RFSH_EN != 0) && (rfsh_pend || hs_rise);

  // Round robin: scan starting at the bank after the last completed grant.
  // At i=4 the index wraps back to last_grant itself.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = last_grant;
    rr_idx = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_grant + 2'(i);
      if (!rr_hit && ba_rd[rr_idx]) begin
        rr_hit = 1'b1;
        rr_sel = rr_idx;
      end
    end
  end

  always_comb begin
    nx_state = state;
    go_req   = 1'b0;
    go_rfsh  = 1'b0;
    case (state)
      IDLE: begin
        if (rfsh_due) begin
          nx_state = RFSH;
          go_rfsh  = 1'b1;
        end else if (rr_hit) begin
          nx_state = REQ;
          go_req   = 1'b1;
        end
      end
      REQ:     if (sdr_ack) nx_state = DATA;
      DATA:    if (sdr_rdy) nx_state = IDLE;
      RFSH:    if (rfsh_cnt == '0) nx_state = IDLE;
      default: nx_state = IDLE;
    endcase
  end

  // Handshake routing is purely a function of the registered state and the
  // held grant, so a requester dropping ba_rd mid-cycle changes nothing.
  assign grant_oh = 4'b0001 << sdr_ba;

  always_comb begin
    sdr_req  = (state == REQ);
    sdr_rfsh = (state == RFSH) && rfsh_first;
    ba_ack   = 4'b0000;
    ba_dst   = 4'b0000;
    ba_rdy   = 4'b0000;
    if (state == REQ && sdr_ack) ba_ack = grant_oh;
    if (state == DATA) begin
      if (sdr_dst) ba_dst = grant_oh;
      if (sdr_rdy) ba_rdy = grant_oh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hs_l       <= 1'b0;
      rfsh_pend  <= 1'b0;
      rfsh_first <= 1'b0;
      rfsh_cnt   <= '0;
      last_grant <= 2'd3;
      sdr_addr   <= 22'd0;
      sdr_ba     <= 2'd0;
    end else begin
      state <= nx_state;
      hs_l  <= hs;

      // Clearing on entry takes priority: the edge that triggered this
      // refresh is consumed, not re-queued.
      if (go_rfsh)
        rfsh_pend <= 1'b0;
      else if (hs_rise)
        rfsh_pend <= 1'b1;

      if (go_req) begin
        sdr_ba   <= rr_sel;
        sdr_addr <= addr_of(rr_sel, ba0_addr, ba1_addr, ba2_addr, ba3_addr);
      end

      if (state == DATA && sdr_rdy)
        last_grant <= sdr_ba;

      if (go_rfsh) begin
        rfsh_cnt   <= RFSH_LOAD;
        rfsh_first <= 1'b1;
      end else if (state == RFSH) begin
        rfsh_first <= 1'b0;
        if (rfsh_cnt != '0)
          rfsh_cnt <= rfsh_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtkunio_ba_arb.sv
module tb_jtkunio_ba_arb;

  localparam logic [21:0] A0 = 22'h00a00;
  localparam logic [21:0] A1 = 22'h01111;
  localparam logic [21:0] A2 = 22'h01234;
  localparam logic [21:0] A3 = 22'h03333;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hs = 1'b0;
  logic [3:0]  ba_rd = 4'b0;
  logic        sdr_ack = 1'b0, sdr_dst = 1'b0, sdr_rdy = 1'b0;
  logic [21:0] ba0_addr = A0, ba1_addr = A1, ba2_addr = A2, ba3_addr = A3;

  logic [3:0]  ba_ack, ba_dst, ba_rdy;
  logic        sdr_req, sdr_rfsh;
  logic [21:0] sdr_addr;
  logic [1:0]  sdr_ba;

  logic [3:0]  z_ack, z_dst, z_rdy;
  logic        z_req, z_rfsh;
  logic [21:0] z_addr;
  logic [1:0]  z_ba;

  int tests = 0;
  int fails = 0;

  jtkunio_ba_arb dut (
    .clk(clk), .rst(rst), .hs(hs),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba), .sdr_rfsh(sdr_rfsh),
    .sdr_ack(sdr_ack), .sdr_dst(sdr_dst), .sdr_rdy(sdr_rdy)
  );

  jtkunio_ba_arb #(.RFSH_CYC(8), .RFSH_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .hs(hs),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_ack(z_ack), .ba_dst(z_dst), .ba_rdy(z_rdy),
    .sdr_req(z_req), .sdr_addr(z_addr), .sdr_ba(z_ba), .sdr_rfsh(z_rfsh),
    .sdr_ack(sdr_ack), .sdr_dst(sdr_dst), .sdr_rdy(sdr_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  rd;
    logic        ack, dst, rdy;
    logic [3:0]  e_ack, e_dst, e_rdy;
    logic        e_req;
    logic [1:0]  e_ba;
    logic [21:0] e_addr;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [63:0] outs();
    return {26'b0, sdr_req, sdr_rfsh, sdr_ba, sdr_addr, ba_ack, ba_dst, ba_rdy};
  endfunction

  function automatic logic [63:0] z_outs();
    return {26'b0, z_req, z_rfsh, z_ba, z_addr, z_ack, z_dst, z_rdy};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; hs = 1'b0; ba_rd = 4'b0;
    sdr_ack = 1'b0; sdr_dst = 1'b0; sdr_rdy = 1'b0;
    #1;
    chk("reset_outs", outs(), 64'd0);
    chk("reset_outs_nr", z_outs(), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!sdr_req && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk(nm, 64'(sdr_req), 64'd1);
  endtask

  // Accept the current request and finish its burst; the bank's request is
  // dropped on ack and optionally re-raised once the burst is over.
  task automatic finish_txn(input logic [1:0] g, input logic reraise);
    sdr_ack = 1'b1;
    #1;
    chk("txn_ack", 64'(ba_ack), 64'(4'b0001 << g));
    tick();
    sdr_ack = 1'b0; ba_rd[g] = 1'b0; sdr_rdy = 1'b1;
    #1;
    chk("txn_rdy", 64'(ba_rdy), 64'(4'b0001 << g));
    tick();
    sdr_rdy = 1'b0;
    if (reraise) ba_rd[g] = 1'b1;
    #1;
  endtask

  initial begin
    int rf_at, req_at, rf_cnt, bad, on_cnt;
    logic first_rfsh;

    //           rd       ack   dst   rdy    e_ack    e_dst    e_rdy    req   ba    addr
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 22'h0};
    tbl[1]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, A2};
    tbl[2]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, A2};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2, A2};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd2, A2};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, A2};
    tbl[6]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, A2};
    tbl[7]  = '{4'b1001, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, A3};
    tbl[8]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'd3, A3};
    tbl[9]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, A3};
    tbl[10] = '{4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1000, 1'b0, 2'd3, A3};
    tbl[11] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, A3};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, A0};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, A0};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, A0};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, A0};

    rst = 1'b1;
    #12;
    do_reset();

    // Directed table: single request, ignored handshakes, dropped request.
    for (int i = 0; i < 16; i++) begin
      tick();
      ba_rd = tbl[i].rd; sdr_ack = tbl[i].ack; sdr_dst = tbl[i].dst; sdr_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {26'b0, tbl[i].e_req, 1'b0, tbl[i].e_ba, tbl[i].e_addr,
           tbl[i].e_ack, tbl[i].e_dst, tbl[i].e_rdy});
    end

    // Round robin with all banks requesting.
    do_reset();
    ba_rd = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_req("rr_req");
      chk($sformatf("rr_grant%0d", k), 64'(sdr_ba), 64'(k % 4));
      finish_txn(2'(k % 4), 1'b1);
    end

    // Refresh beats a request raised on the same cycle as the hs edge.
    do_reset();
    tick();
    hs = 1'b1; ba_rd = 4'b0001;
    #1;
    rf_at = -1; req_at = -1; rf_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (sdr_rfsh) begin
        rf_cnt++;
        if (rf_at < 0) rf_at = c;
      end
      if (sdr_req) begin
        req_at = c;
        break;
      end
      tick();
      #1;
    end
    chk("rfsh_pulses", 64'(rf_cnt), 64'd1);
    chk("rfsh_first_cycle", 64'(rf_at), 64'd1);
    chk("rfsh_to_req", 64'(req_at - rf_at), 64'd9);
    chk("rfsh_then_bank0", 64'(sdr_ba), 64'd0);
    finish_txn(2'd0, 1'b0);
    hs = 1'b0;

    // hs edge during a bank 1 burst: burst completes, then refresh, then bank 0.
    tick();
    ba_rd = 4'b0010;
    wait_req("burst_req");
    chk("burst_bank1", 64'(sdr_ba), 64'd1);
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0; hs = 1'b1; ba_rd = 4'b0001;
    #1;
    chk("burst_no_preempt", 64'({sdr_rfsh, sdr_req}), 64'd0);
    tick();
    sdr_rdy = 1'b1;
    #1;
    chk("burst_rdy1", 64'(ba_rdy), 64'(4'b0010));
    tick();
    sdr_rdy = 1'b0;
    #1;
    first_rfsh = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (sdr_rfsh) begin
        first_rfsh = 1'b1;
        break;
      end
      if (sdr_req) break;
      tick();
      #1;
    end
    chk("burst_then_rfsh", 64'(first_rfsh), 64'd1);
    wait_req("after_rfsh_req");
    chk("after_rfsh_bank0", 64'(sdr_ba), 64'd0);
    finish_txn(2'd0, 1'b0);
    hs = 1'b0;

    // Reset in the middle of a bank 3 burst.
    do_reset();
    ba_rd = 4'b1000;
    wait_req("rst_req");
    chk("rst_bank3", 64'({sdr_ba, sdr_addr}), 64'({2'd3, A3}));
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0; sdr_dst = 1'b1;
    #1;
    chk("rst_dst3", 64'(ba_dst), 64'(4'b1000));
    tick();
    rst = 1'b1; sdr_rdy = 1'b1;
    #1;
    chk("rst_mid_data", outs(), 64'd0);
    tick();
    rst = 1'b0; ba_rd = 4'b0000;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if ({ba_ack, ba_dst, ba_rdy, sdr_req} != 13'd0) bad++;
    end
    chk("rst_stale_ignored", 64'(bad), 64'd0);
    sdr_rdy = 1'b0; sdr_dst = 1'b0; ba_rd = 4'b1001;
    wait_req("rst_rearb_req");
    chk("rst_rearb_bank0", 64'(sdr_ba), 64'd0);
    finish_txn(2'd0, 1'b0);
    ba_rd = 4'b0000;

    // Refresh disabled: hs activity never produces a refresh.
    do_reset();
    bad = 0; on_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      hs = ~hs;
      #1;
      if (z_rfsh || z_req || {z_ack, z_dst, z_rdy} != 12'd0) bad++;
      if (sdr_rfsh) on_cnt++;
    end
    chk("nr_no_rfsh", 64'(bad), 64'd0);
    chk("en_has_rfsh", 64'(on_cnt > 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtkunio_ba_arb.md
JTKUNIO_BA_ARB -- requirements
Module: jtkunio_ba_arb

Interface
REQ-001 SHALL have parameter: RFSH_CYC, default 8, number of clk cycles one refresh slot occupies the SDRAM port.
REQ-002 SHALL have parameter: RFSH_EN, default 1, 1 enables HS-triggered refresh insertion; 0 never issues refresh.
REQ-003 SHALL have ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hs  in  1  horizontal sync; a rising edge requests one refresh slot.
- ba0_addr, ba1_addr, ba2_addr, ba3_addr  in  22 each  word address from bank requesters 0-3.
- ba_rd  in  4  per-bank read request, level, held until the matching ba_ack.
- ba_ack  out  4  per-bank request accepted.
- ba_dst  out  4  per-bank first data word on data bus.
- ba_rdy  out  4  per-bank burst complete.
- sdr_req  out  1  read request to the SDRAM core.
- sdr_addr  out  22  granted address.
- sdr_ba  out  2  granted bank number.
- sdr_rfsh  out  1  refresh command strobe.
- sdr_ack, sdr_dst, sdr_rdy  in  1 each  SDRAM core handshake for the current request.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, DATA, RFSH.
REQ-005 SHALL detect a rising edge of hs (registered previous value) and set rfsh_pend; it is cleared only on entry to RFSH; further edges while pending are merged.
REQ-006 In IDLE with rfsh_pend=1 and RFSH_EN=1, SHALL enter RFSH next cycle, regardless of ba_rd (refresh beats requests).
REQ-007 In IDLE, with no refresh due and any ba_rd bit set, SHALL grant one bank by round robin, starting from the bank after last_grant (reset value 3, so bank 0 is first after reset), and enter REQ next cycle.
REQ-008 Grant, sdr_addr and sdr_ba SHALL be registered on the IDLE->REQ transition and held constant through REQ and DATA.
REQ-009 In REQ, sdr_req SHALL be 1; on sdr_ack=1 the FSM SHALL enter DATA next cycle and sdr_req SHALL be 0 from that cycle.
REQ-010 ba_ack[g] SHALL equal sdr_ack combinationally while in REQ with grant g; all other ba_ack bits 0.
REQ-011 In DATA, ba_dst[g]=sdr_dst and ba_rdy[g]=sdr_rdy combinationally; other bits 0; on sdr_rdy=1 FSM returns to IDLE next cycle and last_grant<=g.
REQ-012 A ba_rd bit dropped by the requester while in REQ before sdr_ack SHALL NOT abort the cycle; the transaction completes and its handshakes are still routed to bank g.
REQ-013 In RFSH, sdr_rfsh SHALL be 1 on the first cycle only; a down-counter loaded with RFSH_CYC-1 SHALL hold RFSH until it reaches 0, then return to IDLE.
REQ-014 An hs rising edge during REQ/DATA/RFSH SHALL only set rfsh_pend; no preemption of an in-flight request.
REQ-015 Minimum IDLE dwell SHALL be one cycle between consecutive transactions (IDLE->REQ->...->IDLE->REQ).
REQ-016 sdr_ack or sdr_rdy asserted outside REQ/DATA respectively SHALL be ignored; no ba_* output toggles.
REQ-017 Counter width SHALL be ceil(log2(RFSH_CYC))+1; RFSH_CYC=1 gives a single-cycle RFSH.

Reset
REQ-018 While rst=1, regardless of clk: state=IDLE, sdr_req=0, sdr_rfsh=0, sdr_addr=0, sdr_ba=0, ba_ack=ba_dst=ba_rdy=0, rfsh_pend=0, last_grant=3, hs edge register=0.
REQ-019 Reset asserted mid-REQ or mid-DATA SHALL abandon the transaction; after release the FSM re-arbitrates from IDLE with no stale handshakes routed.

Verification
REQ-020 Single request: ba_rd=4'b0100, ba2_addr=22'h01234 -> sdr_req next cycle, sdr_ba=2, sdr_addr=22'h01234; sdr_ack -> ba_ack=4'b0100; sdr_rdy -> ba_rdy=4'b0100, IDLE next cycle.
REQ-021 Round robin: ba_rd=4'b1111 held, each acked request dropped and re-raised -> grant order 0,1,2,3,0.
REQ-022 Refresh vs request: hs rises while IDLE and ba_rd=4'b0001 same cycle -> RFSH first, sdr_rfsh one cycle, 8 cycles later bank 0 granted.
REQ-023 Refresh during burst: hs rises in DATA of bank 1 -> burst completes with ba_rdy[1], then RFSH, then pending requests.
REQ-024 Reset mid-DATA: rst pulse while granted bank 3 in DATA -> all outputs 0 immediately; after release, later sdr_rdy ignored, next request granted bank 0 first.
REQ-025 RFSH_EN=0: hs toggles 100 times with no requests -> sdr_rfsh never asserts, FSM stays IDLE.
